// File: rtl/pipe_stage_buffer.sv
// pipe_stage_buffer: elastic valid/ready pipeline-stage register carrying a
// WIDTH-bit payload between two pipeline stages, with synchronous flush for
// branch squash.
//
// Build option PIPE_STAGE_BUFFER_SKID_EN:
//   defined   -> two-entry skid buffer (main + skid), every output registered,
//                no combinational path from out_ready to in_ready.
//   undefined -> single main register; in_ready = !out_valid | out_ready is
//                combinational, occupancy is 0 or 1.
//
// Priority on every clock edge: rst > flush > normal handshake transitions.
// Payload registers are only loaded by an accepted transfer (never on a flush
// cycle), so a squashed payload can never reach out_data.

module pipe_stage_buffer #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occupancy
);

`ifdef PIPE_STAGE_BUFFER_SKID_EN

  // State encoding doubles as the live-entry count.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]       state_r;
  logic [1:0]       state_s;
  logic [WIDTH-1:0] main_r;
  logic [WIDTH-1:0] main_s;
  logic [WIDTH-1:0] skid_r;
  logic [WIDTH-1:0] skid_s;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [1:0]       occupancy_r;
  logic             in_fire_s;
  logic             out_fire_s;

  assign in_fire_s  = in_valid & in_ready_r;
  assign out_fire_s = out_valid_r & out_ready;

  // Next-state and payload-load decisions for the EMPTY/ONE/FULL machine.
  always_comb begin
    state_s = state_r;
    main_s  = main_r;
    skid_s  = skid_r;
    if (flush) begin
      // Squash: drop every live entry, load nothing.
      state_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_fire_s) begin
            state_s = ST_ONE;
            main_s  = in_data;
          end else begin
            state_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_fire_s && out_fire_s) begin
            // Pass-through: new payload replaces the one just delivered.
            state_s = ST_ONE;
            main_s  = in_data;
          end else if (in_fire_s) begin
            // Downstream stalled: the younger payload parks in skid.
            state_s = ST_FULL;
            skid_s  = in_data;
          end else if (out_fire_s) begin
            state_s = ST_EMPTY;
          end else begin
            state_s = ST_ONE;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the drain side can move.
          if (out_fire_s) begin
            state_s = ST_ONE;
            main_s  = skid_r;
          end else begin
            state_s = ST_FULL;
          end
        end
        default: begin
          state_s = ST_EMPTY;
        end
      endcase
    end
  end

  // State, payload and registered handshake outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_EMPTY;
      main_r      <= RESET_VALUE;
      skid_r      <= RESET_VALUE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      occupancy_r <= 2'd0;
    end else begin
      state_r     <= state_s;
      main_r      <= main_s;
      skid_r      <= skid_s;
      in_ready_r  <= (state_s != ST_FULL);
      out_valid_r <= (state_s != ST_EMPTY);
      occupancy_r <= state_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = main_r;
  assign occupancy = occupancy_r;

`else

  logic             valid_r;
  logic             valid_s;
  logic [WIDTH-1:0] main_r;
  logic [WIDTH-1:0] main_s;
  logic             in_ready_s;
  logic             in_fire_s;
  logic             out_fire_s;

  // Single-entry build: the stage can take a payload whenever the held one
  // leaves this cycle, so backpressure is a combinational path.
  assign in_ready_s = ~valid_r | out_ready;
  assign in_fire_s  = in_valid & in_ready_s;
  assign out_fire_s = valid_r & out_ready;

  // Next valid bit and payload for the single main register.
  always_comb begin
    valid_s = valid_r;
    main_s  = main_r;
    if (flush) begin
      valid_s = 1'b0;
    end else if (in_fire_s) begin
      valid_s = 1'b1;
      main_s  = in_data;
    end else if (out_fire_s) begin
      valid_s = 1'b0;
    end else begin
      valid_s = valid_r;
    end
  end

  // Main register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      main_r  <= RESET_VALUE;
    end else begin
      valid_r <= valid_s;
      main_r  <= main_s;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = valid_r;
  assign out_data  = main_r;
  assign occupancy = {1'b0, valid_r};

`endif

endmodule

// File: doc/pipe_stage_buffer.md
# pipe_stage_buffer

Parametrised elastic pipeline-stage register for the MIPS core, the successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers. It carries an arbitrary-width payload between two stages under a valid/ready handshake, with a synchronous flush for branch squash. A two-entry skid buffer lets a cache-miss stall propagate backward one cycle late without losing an instruction. One instance sits between each pair of pipeline stages; the stage buses are packed into the `in_data` vector.

## Interface
- `WIDTH`, 32: payload width in bits (≥1).
- `RESET_VALUE`, `{WIDTH{1'b0}}`: value loaded into all payload registers on reset.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream stage presents a payload.
- `in_ready`  out  1  stage can accept a payload this cycle.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  `out_data` holds a live payload.
- `out_ready`  in  1  downstream accepts this cycle; driven low on a cache miss or hazard stall.
- `out_data`  out  WIDTH  payload to the downstream stage.
- `flush`  in  1  discard all held and incoming payloads; used for branch squash.
- `occupancy`  out  2  number of live entries, 0..2.

## Operation
- Definitions: in_fire = `in_valid & in_ready`; out_fire = `out_valid & out_ready`.
- Storage: main register drives `out_data`/`out_valid`; skid register holds the overflow entry.
- States: EMPTY (occ 0), ONE (main valid), FULL (main+skid valid).
- EMPTY: in_fire → ONE, main ← `in_data`.
- ONE: in_fire & out_fire → ONE, main ← `in_data`. in_fire only → FULL, skid ← `in_data`. out_fire only → EMPTY. Neither → hold.
- FULL: `in_ready`=0, so there is no in_fire. out_fire → ONE, main ← skid. Otherwise hold.
- Order is preserved: the skid entry is always younger than main.
- `flush`=1: next state EMPTY regardless of in_fire/out_fire. A payload accepted by in_fire on the flush cycle is discarded. A payload taken by out_fire on the flush cycle counts as delivered.
- Priority: `rst` > `flush` > normal transitions.
- Payload registers are not cleared by flush; only the valid bits are.
- `out_data` is stable while `out_valid`=1 and `out_ready`=0.
- `in_data` is ignored whenever in_fire=0.

## Timing
- Reset, after a `rst` cycle: `out_valid`=0, `in_ready`=1, `occupancy`=0, `out_data`=`RESET_VALUE`, skid=`RESET_VALUE`.
- `rst` asserted mid-transfer discards all contents, with the same values as above.
- Latency: one cycle from in_fire to `out_valid`, in ONE and EMPTY states.
- Throughput: one payload per cycle while `out_ready` is held high.
- `in_ready`, `out_valid`, `out_data` and `occupancy` are all registered; no combinational path from `out_ready` to `in_ready` (skid build).
- `in_ready`=0 exactly when in state FULL.
- A stall (`out_ready` low) observed in cycle N has `in_ready` low in cycle N+1 at the earliest. The one payload accepted in cycle N lands in skid.
- After a flush cycle N: `out_valid`=0 and `in_ready`=1 in cycle N+1.

## Configuration
- `PIPE_STAGE_BUFFER_SKID_EN` defined (default build): behaviour as above, two entries, fully registered handshake.
- Not defined: single main register, no skid register, `occupancy` ∈ {0,1}.
  - `in_ready` = `!out_valid | out_ready`, combinational.
  - in_fire loads main.
  - `flush`/`rst` semantics are unchanged.
  - Latency and throughput are unchanged; the backpressure path becomes combinational.

## Test plan
- Reset: hold `rst` for 2 cycles with `in_valid`=1 and `in_data`=0xDEAD → `out_valid`=0, `in_ready`=1, `occupancy`=0, `out_data`=0.
- Streaming: `out_ready`=1, send 0x1..0x8 on consecutive cycles → 0x1..0x8 appear in order, one per cycle, starting one cycle after the first in_fire; `occupancy` stays at 1.
- Stall and skid: stream 0xA,0xB,0xC with `out_ready` dropped on the cycle 0xA becomes valid.
  - 0xB lands in skid; `occupancy`=2; `in_ready`=0 next cycle.
  - 0xC is held upstream.
  - Raise `out_ready` → 0xA,0xB,0xC delivered in order with none lost or duplicated.
- Flush while FULL with in_fire=0 → next cycle `out_valid`=0, `occupancy`=0.
- Flush in ONE with simultaneous in_fire of 0x55 → 0x55 never appears on `out_data`.
- Without `PIPE_STAGE_BUFFER_SKID_EN`: while `out_valid`=1, toggling `out_ready` changes `in_ready` in the same cycle; `occupancy` never exceeds 1; the streaming test still passes.
